// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C Wishbone sequencer: i2c_master_top register
// map, CR command bytes, SR bit positions, response error codes, FSM states.
package i2c_seq_pkg;

  localparam logic [2:0] REG_PRERLO = 3'd0;
  localparam logic [2:0] REG_PRERHI = 3'd1;
  localparam logic [2:0] REG_CTR    = 3'd2;
  localparam logic [2:0] REG_TXRRXR = 3'd3;
  localparam logic [2:0] REG_CRSR   = 3'd4;

  localparam logic [7:0] CTR_EN          = 8'h80;
  localparam logic [7:0] CMD_STA_WR      = 8'h90;
  localparam logic [7:0] CMD_WR          = 8'h10;
  localparam logic [7:0] CMD_STO_WR      = 8'h50;
  localparam logic [7:0] CMD_RD_NACK_STO = 8'h68;
  localparam logic [7:0] CMD_STO         = 8'h40;

  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_AL   = 2'd2;

  typedef enum logic [3:0] {
    INIT_PRLO, INIT_PRHI, INIT_CTR, IDLE,
    XFER_TXR, XFER_CR, POLL, STOP_CR, STOP_POLL, READ_RXR, DONE
  } seq_state_e;

endpackage

// File: rtl/wb_single_access.sv
// One classic Wishbone single access.
//   start/we/adr/wdata : request, sampled when no access is in flight
//   done               : high in the ack cycle (combinational)
//   rdata              : read data, valid together with done
//   wb_*               : Wishbone master port
module wb_single_access (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else if (wb_cyc_o && wb_ack_i) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else if (start && !wb_cyc_o) begin
      wb_cyc_o <= 1'b1;
      wb_stb_o <= 1'b1;
      wb_we_o  <= we;
      wb_adr_o <= adr;
      wb_dat_o <= wdata;
    end
  end

  // done in the ack cycle lets the caller capture read data and step its FSM
  // without an extra cycle of latency.
  assign done  = wb_cyc_o & wb_ack_i;
  assign rdata = wb_dat_i;

endmodule

// File: rtl/i2c_wb_sequencer.sv
// Sequencer driving the Wishbone port of i2c_master_top. Programs prescaler
// and enable after reset, then turns single register write/read requests
// into full I2C transactions (START, address, pointer, data, STOP).
//   req_*     : request handshake (valid/ready), rd flag, pointer, write data
//   rsp_*     : one-cycle completion pulse, read data, error code
//   init_done : sticky once the core is enabled
//   wb_*      : Wishbone master port to i2c_master_top
module i2c_wb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd249,
  parameter logic [6:0]  DEV_ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       init_done,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i
);

  seq_state_e state, state_nx;
  // phase: 0 = device address, 1 = pointer, 2 = write data / repeated-start
  // address, 3 = read data byte
  logic [1:0] phase, phase_nx;
  logic       rd_q;
  logic [7:0] addr_q, wdata_q, rdata_q;
  logic [1:0] err_q, err_nx;
  logic       init_q, acc_pend, acc_start, acc_done, acc_we, accept;
  logic [2:0] acc_adr;
  logic [7:0] acc_wdata, acc_rdata;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign accept    = req_valid & req_ready;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign init_done = init_q;

  // Every state except IDLE/DONE performs exactly one access per visit;
  // acc_pend keeps it from being reissued while in flight.
  assign acc_start = (state != IDLE) && (state != DONE) && !acc_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_PRLO;
      phase    <= '0;
      err_q    <= ERR_OK;
      acc_pend <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      init_q   <= 1'b0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      err_q <= err_nx;
      if (acc_start)     acc_pend <= 1'b1;
      else if (acc_done) acc_pend <= 1'b0;
      if (accept) begin
        rd_q    <= req_rd;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == READ_RXR && acc_done) rdata_q <= acc_rdata;
      if (state == INIT_CTR && acc_done) init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    err_nx    = err_q;
    acc_we    = 1'b1;
    acc_adr   = REG_CRSR;
    acc_wdata = 8'h00;
    case (state)
      INIT_PRLO: begin
        acc_adr   = REG_PRERLO;
        acc_wdata = PRESCALE[7:0];
        if (acc_done) state_nx = INIT_PRHI;
      end
      INIT_PRHI: begin
        acc_adr   = REG_PRERHI;
        acc_wdata = PRESCALE[15:8];
        if (acc_done) state_nx = INIT_CTR;
      end
      INIT_CTR: begin
        acc_adr   = REG_CTR;
        acc_wdata = CTR_EN;
        if (acc_done) state_nx = IDLE;
      end
      IDLE: begin
        if (accept) begin
          err_nx   = ERR_OK;
          phase_nx = 2'd0;
          state_nx = XFER_TXR;
        end
      end
      XFER_TXR: begin
        acc_adr = REG_TXRRXR;
        case (phase)
          2'd0:    acc_wdata = {DEV_ADDR, 1'b0};
          2'd1:    acc_wdata = addr_q;
          default: acc_wdata = rd_q ? {DEV_ADDR, 1'b1} : wdata_q;
        endcase
        if (acc_done) state_nx = XFER_CR;
      end
      XFER_CR: begin
        case (phase)
          2'd0:    acc_wdata = CMD_STA_WR;
          2'd1:    acc_wdata = CMD_WR;
          2'd2:    acc_wdata = rd_q ? CMD_STA_WR : CMD_STO_WR;
          default: acc_wdata = CMD_RD_NACK_STO;
        endcase
        if (acc_done) state_nx = POLL;
      end
      POLL: begin
        acc_we = 1'b0;
        if (acc_done && !acc_rdata[SR_TIP]) begin
          if (acc_rdata[SR_AL]) begin
            // core has already released the bus; no STOP
            err_nx   = ERR_AL;
            state_nx = DONE;
          end else if (acc_rdata[SR_RXACK] && phase != 2'd3) begin
            state_nx = STOP_CR;
          end else if (!rd_q && phase == 2'd2) begin
            state_nx = DONE;
          end else if (phase == 2'd3) begin
            state_nx = READ_RXR;
          end else begin
            phase_nx = phase + 2'd1;
            // the read-data byte has no TXR load, only a command
            state_nx = (rd_q && phase == 2'd2) ? XFER_CR : XFER_TXR;
          end
        end
      end
      STOP_CR: begin
        acc_wdata = CMD_STO;
        if (acc_done) state_nx = STOP_POLL;
      end
      STOP_POLL: begin
        acc_we = 1'b0;
        if (acc_done && !acc_rdata[SR_TIP]) begin
          err_nx   = ERR_NACK;
          state_nx = DONE;
        end
      end
      READ_RXR: begin
        acc_we  = 1'b0;
        acc_adr = REG_TXRRXR;
        if (acc_done) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = INIT_PRLO;
    endcase
  end

  wb_single_access u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (acc_start),
    .we       (acc_we),
    .adr      (acc_adr),
    .wdata    (acc_wdata),
    .done     (acc_done),
    .rdata    (acc_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_ack_i (wb_ack_i)
  );

endmodule
